// File: rtl/ibex_msg_loader.sv
// ibex_msg_loader: buffers a descriptor-addressed word stream in a FIFO
// and writes it into consecutive message registers, yielding to the core.
module ibex_msg_loader #(
   parameter int unsigned RV32E     = 0,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned FifoDepth = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 desc_req_i,
   output logic                 desc_gnt_o,
   input  logic [4:0]           desc_base_i,
   input  logic [1:0]           desc_len_i,
   input  logic                 data_valid_i,
   output logic                 data_ready_o,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 core_mprf_we_i,
   input  logic                 abort_i,
   output logic                 input_valid_o,
   output logic [4:0]           input_addr_o,
   output logic [DataWidth-1:0] input_data_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam logic [PtrW:0] Depth = FifoDepth[PtrW:0];

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [4:0]           base_q, base_d;
   logic [1:0]           len_q, len_d;
   logic [2:0]           acc_cnt_q, acc_cnt_d;
   logic [2:0]           wr_cnt_q, wr_cnt_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]        cnt_q, cnt_d;
   logic [DataWidth-1:0] mem_q [FifoDepth];
   logic [DataWidth-1:0] mem_d [FifoDepth];

   logic       in_load;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       pop;
   logic [4:0] addr_sum;

   assign in_load    = (state_q == StLoad);
   assign fifo_full  = (cnt_q == Depth);
   assign fifo_empty = (cnt_q == '0);

   assign data_ready_o  = in_load & ~fifo_full
                        & (acc_cnt_q <= {1'b0, len_q});
   assign push          = data_valid_i & data_ready_o;
   assign input_valid_o = in_load & ~fifo_empty
                        & ~core_mprf_we_i & ~abort_i;
   assign pop           = input_valid_o;

   assign input_data_o = mem_q[rd_ptr_q];
   assign addr_sum     = base_q + {2'b00, wr_cnt_q};
   assign input_addr_o = (RV32E != 0) ? {1'b0, addr_sum[3:0]}
                                      : addr_sum;

   assign desc_gnt_o = (state_q == StIdle);
   assign busy_o     = (state_q != StIdle);
   assign done_o     = (state_q == StDone);

   // Next-state: FIFO push/pop, counters and descriptor sequencing.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      acc_cnt_d = acc_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      cnt_d     = cnt_q;
      mem_d     = mem_q;

      if (push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d  = wr_ptr_q + PtrW'(1);
         acc_cnt_d = acc_cnt_q + 3'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
         wr_cnt_d = wr_cnt_q + 3'd1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
         default: cnt_d = cnt_q;
      endcase

      case (state_q)
         StIdle: begin
            if (desc_req_i) begin
               base_d    = desc_base_i;
               len_d     = desc_len_i;
               acc_cnt_d = '0;
               wr_cnt_d  = '0;
               state_d   = StLoad;
            end
         end
         StLoad: begin
            if (pop && (wr_cnt_q == {1'b0, len_q})) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (abort_i && (state_q != StIdle)) begin
         state_d   = StIdle;
         acc_cnt_d = '0;
         wr_cnt_d  = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         cnt_d     = '0;
      end
   end

   // Control and pointer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         base_q    <= '0;
         len_q     <= '0;
         acc_cnt_q <= '0;
         wr_cnt_q  <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         acc_cnt_q <= acc_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   // FIFO storage, cleared on reset so the write data port reads zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(FifoDepth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: tb/tb_ibex_msg_loader.sv
// tb_ibex_msg_loader: two loader configurations driven in parallel,
// each tracked by a queue-based reference of the expected writes.
module tb_ibex_msg_loader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req, dv, cwe, abrt;
   logic [4:0]  base;
   logic [1:0]  len;
   logic [31:0] din;

   logic        gnt [2];
   logic        rdy [2];
   logic        iv  [2];
   logic        bsy [2];
   logic        dne [2];
   logic [4:0]  addr [2];
   logic [31:0] wdat [2];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int D = (g == 0) ? 4 : 2;
      localparam int M = (g == 0) ? 31 : 15;

      ibex_msg_loader #(
         .RV32E(g), .DataWidth(32), .FifoDepth(D)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n),
         .desc_req_i(req), .desc_gnt_o(gnt[g]),
         .desc_base_i(base), .desc_len_i(len),
         .data_valid_i(dv), .data_ready_o(rdy[g]), .data_i(din),
         .core_mprf_we_i(cwe), .abort_i(abrt),
         .input_valid_o(iv[g]), .input_addr_o(addr[g]),
         .input_data_o(wdat[g]),
         .busy_o(bsy[g]), .done_o(dne[g])
      );

      // Reference: queue holds exactly the words accepted but not yet written.
      wr_t q[$];
      wr_t h;
      int  st = 0;
      int  mbase = 0, mlen = 0, macc = 0, mwr = 0;
      bit  e_iv, e_rdy;

      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
            st = 0; macc = 0; mwr = 0;
         end else begin
            e_rdy = (st == 1) && (q.size() < D) && (macc <= mlen);
            e_iv  = (st == 1) && (q.size() > 0) && !cwe && !abrt;
            chk($sformatf("gnt%0d", g), 64'(gnt[g]), 64'(st == 0));
            chk($sformatf("busy%0d", g), 64'(bsy[g]), 64'(st != 0));
            chk($sformatf("done%0d", g), 64'(dne[g]), 64'(st == 2));
            chk($sformatf("ready%0d", g), 64'(rdy[g]), 64'(e_rdy));
            chk($sformatf("strobe%0d", g), 64'(iv[g]), 64'(e_iv));
            if (e_iv && iv[g]) begin
               h = q[0];
               chk($sformatf("addr%0d", g), 64'(addr[g]), 64'(h.a));
               chk($sformatf("data%0d", g), 64'(wdat[g]), 64'(h.d));
            end
            case (st)
               0: if (req) begin
                  mbase = int'(base); mlen = int'(len);
                  macc = 0; mwr = 0; st = 1;
               end
               1: if (abrt) begin
                  q.delete(); st = 0;
               end else begin
                  if (e_iv) begin
                     void'(q.pop_front());
                     if (mwr == mlen) st = 2;
                     mwr++;
                  end
                  if (e_rdy && dv) begin
                     q.push_back('{a: 5'((mbase + macc) & M), d: din});
                     macc++;
                  end
               end
               default: begin
                  q.delete(); st = 0;
               end
            endcase
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      req = 0; dv = 0; cwe = 0; abrt = 0;
      base = '0; len = '0; din = '0;
   endtask

   task automatic reset_vals(input string tag);
      for (int g = 0; g < 2; g++) begin
         chk({tag, "_iv"}, 64'(iv[g]), 64'(0));
         chk({tag, "_addr"}, 64'(addr[g]), 64'(0));
         chk({tag, "_data"}, 64'(wdat[g]), 64'(0));
         chk({tag, "_rdy"}, 64'(rdy[g]), 64'(0));
         chk({tag, "_gnt"}, 64'(gnt[g]), 64'(1));
         chk({tag, "_busy"}, 64'(bsy[g]), 64'(0));
         chk({tag, "_done"}, 64'(dne[g]), 64'(0));
      end
   endtask

   int hs, nw;

   initial begin
      quiet();
      rst_n = 0;
      repeat (3) step();
      reset_vals("rst");
      rst_n = 1;
      step();

      // Single word to register 5.
      req = 1; base = 5'd5; len = 2'd0; step();
      req = 0; dv = 1; din = 32'hDEADBEEF; step();
      dv = 0;
      @(negedge clk);
      chk("single_iv", 64'(iv[0]), 64'(1));
      chk("single_addr", 64'(addr[0]), 64'(5));
      chk("single_data", 64'(wdat[0]), 64'hDEADBEEF);
      step();
      @(negedge clk);
      chk("single_done", 64'(dne[0]), 64'(1));
      step();
      @(negedge clk);
      chk("single_idle", 64'(bsy[0]), 64'(0));
      repeat (2) step();

      // Four words wrapping past the top register.
      req = 1; base = 5'd30; len = 2'd3; step();
      req = 0; dv = 1;
      for (int i = 0; i < 4; i++) begin
         din = 32'hA0 + 32'(i);
         step();
         @(negedge clk);
         chk("wrap_addr0", 64'(addr[0]), 64'((30 + i) % 32));
         chk("wrap_addr1", 64'(addr[1]), 64'((14 + i) % 16));
      end
      dv = 0;
      repeat (6) step();

      // Core write collides with the first loader write.
      req = 1; base = 5'd10; len = 2'd1; step();
      req = 0; dv = 1; din = 32'h11; step();
      din = 32'h22; cwe = 1;
      @(negedge clk);
      chk("conflict_hold", 64'(iv[0]), 64'(0));
      step();
      dv = 0; cwe = 0;
      repeat (6) step();

      // Backpressure while the core hogs the port.
      req = 1; base = 5'd3; len = 2'd3; step();
      req = 0; dv = 1; cwe = 1; hs = 0;
      for (int i = 0; i < 4; i++) begin
         din = $urandom;
         @(negedge clk);
         if (rdy[1]) hs++;
         if (i == 3) chk("bp_rdy_low", 64'(rdy[1]), 64'(0));
         step();
      end
      chk("bp_accepted", 64'(hs), 64'(2));
      cwe = 0;
      for (int i = 0; i < 8; i++) begin
         din = $urandom;
         step();
      end
      dv = 0;
      repeat (6) step();

      // Abort after two of four writes.
      req = 1; base = 5'd20; len = 2'd3; step();
      req = 0; dv = 1; nw = 0;
      for (int i = 0; i < 4; i++) begin
         din = 32'hB0 + 32'(i);
         abrt = (i == 3);
         @(negedge clk);
         if (iv[0]) nw++;
         step();
      end
      abrt = 0; dv = 0;
      chk("abort_writes", 64'(nw), 64'(2));
      @(negedge clk);
      chk("abort_idle", 64'(bsy[0]), 64'(0));
      step();
      req = 1; base = 5'd0; len = 2'd1; step();
      req = 0; dv = 1; din = 32'hC0; step();
      din = 32'hC1; step();
      dv = 0;
      repeat (6) step();

      // Randomised traffic.
      for (int c = 0; c < 3000; c++) begin
         req  = ($urandom_range(0, 99) < 30);
         dv   = ($urandom_range(0, 99) < 70);
         cwe  = ($urandom_range(0, 99) < 20);
         abrt = ($urandom_range(0, 99) < 3);
         base = 5'($urandom);
         len  = 2'($urandom);
         din  = $urandom;
         step();
      end
      quiet();
      abrt = 1; step();
      abrt = 0; step();

      // Asynchronous reset with words still buffered.
      req = 1; base = 5'd7; len = 2'd3; step();
      req = 0; dv = 1; cwe = 1; din = 32'h12345678; step();
      din = 32'h9ABCDEF0; step();
      dv = 0;
      chk("prerst_busy", 64'(bsy[0]), 64'(1));
      #2 rst_n = 0;
      #1 reset_vals("async");
      step();
      cwe = 0;
      rst_n = 1;
      @(negedge clk);
      chk("post_gnt0", 64'(gnt[0]), 64'(1));
      chk("post_gnt1", 64'(gnt[1]), 64'(1));
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
